// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: shared AHB-lite encodings for the response multiplexer.
//   HTRANS_* : transfer type codes (bit1 set means an active NONSEQ/SEQ)
//   HRESP_*  : response codes driven on HRESP
//   resp_state_t : states of the shared 2-cycle ERROR responder
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } resp_state_t;

endpackage

// File: rtl/ahb_err_resp_gen.sv
// ahb_err_resp_gen: two-cycle AHB ERROR responder shared by the default
// slave and the stall watchdog.
//   clk    in  : system clock, rising edge
//   reset  in  : asynchronous active-low reset
//   start  in  : request an ERROR response (ignored while in ERR1)
//   hready out : 0 in ERR1, 1 otherwise (registered)
//   hresp  out : ERROR in ERR1/ERR2, OKAY in IDLE (registered)
//   busy   out : 1 while the responder owns the data phase (registered)
module ahb_err_resp_gen
  import ahb_lite_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic hready,
  output logic hresp,
  output logic busy
);

  resp_state_t state;

  // State register with outputs computed alongside the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      hready <= 1'b1;
      hresp  <= HRESP_OKAY;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= ERR1;
            hready <= 1'b0;
            hresp  <= HRESP_ERROR;
            busy   <= 1'b1;
          end else begin
            state  <= IDLE;
            hready <= 1'b1;
            hresp  <= HRESP_OKAY;
            busy   <= 1'b0;
          end
        end
        ERR1: begin
          state  <= ERR2;
          hready <= 1'b1;
          hresp  <= HRESP_ERROR;
          busy   <= 1'b1;
        end
        ERR2: begin
          // ERR2 completes the transfer, so a new capture happens here and
          // may immediately request another error.
          if (start) begin
            state  <= ERR1;
            hready <= 1'b0;
            hresp  <= HRESP_ERROR;
            busy   <= 1'b1;
          end else begin
            state  <= IDLE;
            hready <= 1'b1;
            hresp  <= HRESP_OKAY;
            busy   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          hready <= 1'b1;
          hresp  <= HRESP_OKAY;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// ahb_resp_mux: AHB-lite slave-to-master response multiplexer with a
// built-in default slave and a stall watchdog.
//   clk          in  : system clock, rising edge
//   reset        in  : asynchronous active-low reset
//   HSEL         in  : one-hot address-phase select from the decoder
//   HTRANS       in  : master transfer type
//   HRDATA_S     in  : packed slave read data, slave i at [i*DATA_W +: DATA_W]
//   HREADYOUT_S  in  : per-slave ready
//   HRESP_S      in  : per-slave response (1 = ERROR)
//   HRDATA       out : read data to master
//   HREADY       out : transfer-done to master and all slaves
//   HRESP        out : response to master
//   timeout_evt  out : one-cycle pulse when the watchdog fires
//   sel_err      out : one-cycle pulse when a multi-hot HSEL is captured
module ahb_resp_mux
  import ahb_lite_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_SLAVES-1:0]        HSEL,
  input  logic [1:0]                   HTRANS,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic                         timeout_evt,
  output logic                         sel_err
);

  // A zero TIMEOUT still needs a 1-bit counter so the declarations stay legal.
  localparam int WC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WC_W-1:0]       WC_MAX   = WC_W'(TIMEOUT);
  localparam logic [WC_W-1:0]       WC_ONE   = WC_W'(1);
  localparam logic [NUM_SLAVES-1:0] SEL_ZERO = {NUM_SLAVES{1'b0}};
  localparam logic [NUM_SLAVES-1:0] SEL_ONE  = NUM_SLAVES'(1);

  function automatic logic is_onehot(input logic [NUM_SLAVES-1:0] v);
    return (v != SEL_ZERO) && ((v & (v - SEL_ONE)) == SEL_ZERO);
  endfunction

  logic [NUM_SLAVES-1:0] sel_q;
  logic [WC_W-1:0]       wait_cnt;
  logic                  timeout_evt_r;
  logic                  sel_err_r;

  logic                  hsel_zero_s, hsel_multi_s, act_trans_s, dflt_s;
  logic                  sel_onehot_s, slave_path_s;
  logic [DATA_W-1:0]     rdata_sel_s;
  logic                  rdy_sel_s, resp_sel_s;
  logic                  wd_stall_s, wd_fire_s, capture_s, start_s;
  logic                  err_hready_s, err_hresp_s, err_busy_s;

  assign hsel_zero_s  = (HSEL == SEL_ZERO);
  assign hsel_multi_s = !hsel_zero_s && !is_onehot(HSEL);
  assign act_trans_s  = !((HTRANS == HTRANS_IDLE) || (HTRANS == HTRANS_BUSY));
  // Multi-hot selects go to the default slave whatever the transfer type.
  assign dflt_s       = hsel_multi_s || (hsel_zero_s && act_trans_s);

  assign sel_onehot_s = is_onehot(sel_q);
  assign slave_path_s = !err_busy_s && sel_onehot_s;

  // AND-OR mux of the slave responses; sel_q is one-hot whenever it is used.
  always_comb begin
    rdata_sel_s = {DATA_W{1'b0}};
    rdy_sel_s   = 1'b0;
    resp_sel_s  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      rdata_sel_s = rdata_sel_s | (HRDATA_S[i*DATA_W +: DATA_W] & {DATA_W{sel_q[i]}});
      rdy_sel_s   = rdy_sel_s   | (HREADYOUT_S[i] & sel_q[i]);
      resp_sel_s  = resp_sel_s  | (HRESP_S[i] & sel_q[i]);
    end
  end

  // Master-side response: ERROR responder, selected slave, or idle OKAY.
  always_comb begin
    HRDATA = {DATA_W{1'b0}};
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    if (err_busy_s) begin
      HRDATA = {DATA_W{1'b0}};
      HREADY = err_hready_s;
      HRESP  = err_hresp_s;
    end else if (sel_onehot_s) begin
      HRDATA = rdata_sel_s;
      HREADY = rdy_sel_s;
      HRESP  = resp_sel_s;
    end else begin
      HRDATA = {DATA_W{1'b0}};
      HREADY = 1'b1;
      HRESP  = HRESP_OKAY;
    end
  end

  // The watchdog fires only while the slave is still low in the cycle the
  // counter sits at TIMEOUT, so a slave rising in that cycle wins.
  assign wd_stall_s = slave_path_s && !rdy_sel_s;
  assign wd_fire_s  = (TIMEOUT > 0) && wd_stall_s && (wait_cnt == WC_MAX);
  assign capture_s  = HREADY;
  assign start_s    = (capture_s && dflt_s) || wd_fire_s;

  // Select capture, wait-state counter and event pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q         <= SEL_ZERO;
      wait_cnt      <= {WC_W{1'b0}};
      timeout_evt_r <= 1'b0;
      sel_err_r     <= 1'b0;
    end else begin
      timeout_evt_r <= wd_fire_s;
      sel_err_r     <= capture_s && hsel_multi_s;
      if (capture_s) begin
        sel_q <= HSEL;
      end
      if (HREADY) begin
        wait_cnt <= {WC_W{1'b0}};
      end else if (wd_stall_s && (wait_cnt != WC_MAX)) begin
        wait_cnt <= wait_cnt + WC_ONE;
      end
    end
  end

  assign timeout_evt = timeout_evt_r;
  assign sel_err     = sel_err_r;

  ahb_err_resp_gen u_err (
    .clk    (clk),
    .reset  (reset),
    .start  (start_s),
    .hready (err_hready_s),
    .hresp  (err_hresp_s),
    .busy   (err_busy_s)
  );

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Scoreboard bench for ahb_resp_mux: each issued transfer pushes the
// expected data-phase outcome; a monitor pops it when the phase completes.
module tb_ahb_resp_mux;
  import ahb_lite_pkg::*;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS-1:0]     HSEL;
  logic [1:0]        HTRANS;
  logic [NS*DW-1:0]  HRDATA_S;
  logic [NS-1:0]     HREADYOUT_S;
  logic [NS-1:0]     HRESP_S;
  logic [DW-1:0]     HRDATA;
  logic              HREADY;
  logic              HRESP;
  logic              timeout_evt;
  logic              sel_err;

  ahb_resp_mux #(.NUM_SLAVES(NS), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .HSEL(HSEL), .HTRANS(HTRANS),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .timeout_evt(timeout_evt), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          resp;
    int            stalls;
    int            tevt;
    int            serr;
    logic          chk_pre;
    logic          pre_resp;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // current data-phase slave behaviour
  int            cur_idx = -1;
  int            cur_w   = 0;
  bit            cur_err = 1'b0;
  logic [DW-1:0] cur_data;
  int            ph_cycle = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  // Reference model: outcome of one data phase from the select rules.
  function automatic exp_t model(input logic [NS-1:0] hsel, input logic [1:0] htrans,
                                 input int w, input bit err, input logic [DW-1:0] data);
    exp_t e;
    int ones;
    int low;
    ones = $countones(hsel);
    e.data = '0; e.resp = 1'b0; e.stalls = 0; e.tevt = 0; e.serr = 0;
    e.chk_pre = 1'b0; e.pre_resp = 1'b0;
    if (ones > 1) begin
      e.resp = 1'b1; e.stalls = 1; e.serr = 1; e.chk_pre = 1'b1; e.pre_resp = 1'b1;
    end else if (ones == 0) begin
      if (htrans[1]) begin
        e.resp = 1'b1; e.stalls = 1; e.chk_pre = 1'b1; e.pre_resp = 1'b1;
      end
    end else begin
      low = w + (err ? 1 : 0);
      if (TO > 0 && low > TO) begin
        e.resp = 1'b1; e.stalls = TO + 2; e.tevt = 1; e.chk_pre = 1'b1; e.pre_resp = 1'b1;
      end else begin
        e.stalls = low; e.resp = err; e.data = data;
        if (low > 0) begin
          e.chk_pre = 1'b1; e.pre_resp = err;
        end
      end
    end
    return e;
  endfunction

  task automatic drive_slaves();
    for (int j = 0; j < NS; j++) begin
      if (j == cur_idx) begin
        if (ph_cycle < cur_w) begin
          HREADYOUT_S[j] = 1'b0; HRESP_S[j] = 1'b0; HRDATA_S[j*DW +: DW] = $urandom;
        end else if (cur_err && ph_cycle == cur_w) begin
          HREADYOUT_S[j] = 1'b0; HRESP_S[j] = 1'b1; HRDATA_S[j*DW +: DW] = $urandom;
        end else begin
          HREADYOUT_S[j] = 1'b1; HRESP_S[j] = cur_err; HRDATA_S[j*DW +: DW] = cur_data;
        end
      end else begin
        HREADYOUT_S[j] = 1'($urandom_range(0, 1));
        HRESP_S[j]     = 1'($urandom_range(0, 1));
        HRDATA_S[j*DW +: DW] = $urandom;
      end
    end
  endtask

  task automatic present(input logic [NS-1:0] hsel, input logic [1:0] htrans,
                         input int w, input bit err, input logic [DW-1:0] data);
    HSEL   = hsel;
    HTRANS = htrans;
    sb.push_back(model(hsel, htrans, w, err, data));
    cur_idx = -1;
    if ($countones(hsel) == 1) begin
      for (int k = 0; k < NS; k++) begin
        if (hsel[k]) cur_idx = k;
      end
    end
    cur_w = w; cur_err = err; cur_data = data; ph_cycle = 0;
  endtask

  // Wait for an address-phase slot (HREADY high), then present the transfer.
  task automatic issue(input logic [NS-1:0] hsel, input logic [1:0] htrans,
                       input int w, input bit err, input logic [DW-1:0] data);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      drive_slaves();
      #1;
      if (HREADY === 1'b1) got = 1'b1;
      else ph_cycle++;
    end
    if (!got) begin
      chk("hready_wait_bound", 64'd0, 64'd1);
      summary_and_finish();
    end
    present(hsel, htrans, w, err, data);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hready"}, 64'(HREADY), 64'd1);
    chk({tag, "_hresp"},  64'(HRESP), 64'd0);
    chk({tag, "_hrdata"}, 64'(HRDATA), 64'd0);
    chk({tag, "_tevt"},   64'(timeout_evt), 64'd0);
    chk({tag, "_selerr"}, 64'(sel_err), 64'd0);
  endtask

  // Monitor: counts stall cycles and pulses, compares on each completion.
  bit   in_phase = 1'b0;
  int   m_stalls, m_tevt, m_serr;
  logic m_last_resp;
  exp_t m_e;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b1) begin
        in_phase = 1'b0;
        continue;
      end
      if (in_phase) begin
        m_tevt += int'(timeout_evt);
        m_serr += int'(sel_err);
      end
      if (HREADY === 1'b1) begin
        if (in_phase) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 64'd0, 64'd1);
          end else begin
            m_e = sb.pop_front();
            chk("stalls", 64'(m_stalls), 64'(m_e.stalls));
            chk("hresp",  64'(HRESP), 64'(m_e.resp));
            chk("hrdata", 64'(HRDATA), 64'(m_e.data));
            chk("timeout_evt_cnt", 64'(m_tevt), 64'(m_e.tevt));
            chk("sel_err_cnt", 64'(m_serr), 64'(m_e.serr));
            if (m_e.chk_pre) chk("pre_cycle_hresp", 64'(m_last_resp), 64'(m_e.pre_resp));
          end
        end
        in_phase = 1'b1;
        m_stalls = 0; m_tevt = 0; m_serr = 0; m_last_resp = 1'b0;
      end else if (in_phase) begin
        m_stalls++;
        m_last_resp = HRESP;
      end
    end
  end

  initial begin
    #2000000;
    chk("global_time_bound", 64'd0, 64'd1);
    summary_and_finish();
  end

  task automatic random_txn();
    logic [NS-1:0] one;
    logic [NS-1:0] hs;
    logic [1:0]    ht;
    int            r, w;
    bit            err;
    one = 4'b0001;
    r = $urandom_range(0, 99);
    w = 0; err = 1'b0;
    if (r < 12) begin
      hs = '0; ht = {1'b0, 1'($urandom_range(0, 1))};
    end else if (r < 22) begin
      hs = '0; ht = {1'b1, 1'($urandom_range(0, 1))};
    end else if (r < 30) begin
      hs = 4'b0011;
      for (int t = 0; t < 50; t++) begin
        hs = 4'($urandom_range(0, 15));
        if ($countones(hs) > 1) break;
      end
      if ($countones(hs) < 2) hs = 4'b1100;
      ht = 2'($urandom_range(0, 3));
    end else begin
      hs  = one << $urandom_range(0, NS - 1);
      ht  = {1'b1, 1'($urandom_range(0, 1))};
      w   = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 4) : $urandom_range(12, 20);
      err = ($urandom_range(0, 4) == 0);
    end
    issue(hs, ht, w, err, $urandom);
  endtask

  initial begin
    reset = 1'b0;
    HSEL = '0; HTRANS = HTRANS_IDLE;
    HRDATA_S = '0; HREADYOUT_S = '1; HRESP_S = '0;
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    present('0, HTRANS_IDLE, 0, 1'b0, '0);

    // slave 1 with two wait states
    issue(4'b0010, HTRANS_NONSEQ, 2, 1'b0, 32'hDEADBEEF);
    // unmapped, then back-to-back unmapped
    issue(4'b0000, HTRANS_NONSEQ, 0, 1'b0, '0);
    issue(4'b0000, HTRANS_NONSEQ, 0, 1'b0, '0);
    issue(4'b0000, HTRANS_SEQ, 0, 1'b0, '0);
    // idle / busy to nobody
    issue(4'b0000, HTRANS_IDLE, 0, 1'b0, '0);
    issue(4'b0000, HTRANS_BUSY, 0, 1'b0, '0);
    // watchdog: slave 2 rises late, in the ERR1 cycle; then never within budget
    issue(4'b0100, HTRANS_NONSEQ, TO + 1, 1'b0, 32'h12345678);
    issue(4'b0100, HTRANS_NONSEQ, 30, 1'b0, 32'h0BADF00D);
    // multi-hot select
    issue(4'b0011, HTRANS_NONSEQ, 0, 1'b0, '0);
    // slave rises exactly when the counter reaches TIMEOUT, twice in a row
    issue(4'b0100, HTRANS_NONSEQ, TO, 1'b0, 32'hCAFE0001);
    issue(4'b0100, HTRANS_SEQ, TO, 1'b0, 32'hCAFE0002);
    // slave ERROR pass-through at and just past the watchdog boundary
    issue(4'b1000, HTRANS_NONSEQ, TO - 1, 1'b1, 32'hA5A5A5A5);
    issue(4'b1000, HTRANS_NONSEQ, TO, 1'b1, 32'h5A5A5A5A);
    issue(4'b0001, HTRANS_NONSEQ, 0, 1'b1, 32'h00C0FFEE);
    issue(4'b0001, HTRANS_NONSEQ, 0, 1'b0, 32'h11111111);

    for (int n = 0; n < 200; n++) random_txn();

    // reset in the middle of a stalled transfer
    issue(4'b0010, HTRANS_NONSEQ, 10, 1'b0, 32'h77777777);
    repeat (3) begin
      @(negedge clk);
      drive_slaves();
      ph_cycle++;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    sb.delete();
    cur_idx = -1;
    HSEL = '0; HTRANS = HTRANS_IDLE;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    present('0, HTRANS_IDLE, 0, 1'b0, '0);

    issue(4'b0010, HTRANS_NONSEQ, 1, 1'b0, 32'h89ABCDEF);
    for (int n = 0; n < 40; n++) random_txn();

    issue(4'b0000, HTRANS_IDLE, 0, 1'b0, '0);
    issue(4'b0000, HTRANS_IDLE, 0, 1'b0, '0);
    #2;
    chk("sb_drain", 64'(sb.size()), 64'd1);
    summary_and_finish();
  end

endmodule
